// File: rtl/isa_bus_pkg.sv
// Shared ISA bus definitions: widths, default cycle timing, sequencer state codes.
// Also provides the request record and counter sizing helpers.
package isa_bus_pkg;

  localparam int ISA_ADDR_W = 16;
  localparam int ISA_DATA_W = 16;

  localparam int DEF_SETUP_CYCLES   = 2;
  localparam int DEF_STROBE_CYCLES  = 8;
  localparam int DEF_HOLD_CYCLES    = 2;
  localparam int DEF_TIMEOUT_CYCLES = 1024;

  typedef logic [2:0] seq_state_t;

  localparam seq_state_t ST_IDLE     = 3'd0;
  localparam seq_state_t ST_LOAD     = 3'd1;
  localparam seq_state_t ST_SETUP    = 3'd2;
  localparam seq_state_t ST_STROBE   = 3'd3;
  localparam seq_state_t ST_WAIT_RDY = 3'd4;
  localparam seq_state_t ST_HOLD     = 3'd5;
  localparam seq_state_t ST_RESPOND  = 3'd6;

  typedef struct packed {
    logic                  write;
    logic [ISA_ADDR_W-1:0] addr;
    logic [ISA_DATA_W-1:0] wdata;
  } isa_req_t;

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  // The counter only ever holds (cycles - 1), so clog2(max) bits suffice.
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val);
  endfunction

endpackage

// File: rtl/isa_io_cycle_sequencer_if.sv
// HPS request/response port plus the bus-interface-side signals of the I/O cycle sequencer.
// slave = the sequencer, master = the HPS requester together with the ISA bus side.
interface isa_io_cycle_sequencer_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic        rsp_timeout;
  logic [15:0] address_HPS;
  logic [15:0] data_HPS;
  logic        address_load;
  logic        data_load;
  logic        IOW;
  logic        IOR;
  logic        iochrdy;
  logic [15:0] bus_rdata;

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, iochrdy, bus_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_timeout,
           address_HPS, data_HPS, address_load, data_load, IOW, IOR
  );

  modport master (
    output req_valid, req_write, req_addr, req_wdata, iochrdy, bus_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_timeout,
           address_HPS, data_HPS, address_load, data_load, IOW, IOR
  );

endinterface

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchronizer for asynchronous ISA inputs.
// RESET_VAL lets inactive-high and inactive-low inputs start in their idle level.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/isa_io_cycle_sequencer.sv
// Runs one 16-bit ISA I/O read or write cycle per HPS request with programmed
// setup/strobe/hold timing, IOCHRDY wait-stretching with timeout, and a one-clock response.
module isa_io_cycle_sequencer
  import isa_bus_pkg::*;
#(
  parameter int SETUP_CYCLES   = DEF_SETUP_CYCLES,
  parameter int STROBE_CYCLES  = DEF_STROBE_CYCLES,
  parameter int HOLD_CYCLES    = DEF_HOLD_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                      clk,
  input  logic                      reset,
  isa_io_cycle_sequencer_if.slave   bus
);

  localparam int CNT_MAX = max4(SETUP_CYCLES, STROBE_CYCLES, HOLD_CYCLES, TIMEOUT_CYCLES);
  localparam int CNT_W   = cnt_width(CNT_MAX);

  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t SETUP_LOAD   = cnt_t'(SETUP_CYCLES - 1);
  localparam cnt_t STROBE_LOAD  = cnt_t'(STROBE_CYCLES - 1);
  localparam cnt_t HOLD_LOAD    = cnt_t'(HOLD_CYCLES - 1);
  localparam cnt_t TIMEOUT_LOAD = cnt_t'(TIMEOUT_CYCLES - 1);

  seq_state_t        state_q, state_d;
  cnt_t              cnt_q, cnt_d;
  isa_req_t          req_q, req_d;
  logic              timeout_q, timeout_d;
  logic [ISA_DATA_W-1:0] rdata_q, rdata_d;

  logic req_ready_q;
  logic rsp_valid_q;
  logic rsp_timeout_q;
  logic address_load_q;
  logic data_load_q;
  logic iow_q;
  logic ior_q;

  logic rdy_sync;
  logic strobe_d;
  logic cnt_zero;

  sync_2ff #(
    .RESET_VAL (1'b1)
  ) u_iochrdy_sync (
    .clk   (clk),
    .reset (reset),
    .d_i   (bus.iochrdy),
    .q_o   (rdy_sync)
  );

  assign cnt_zero = (cnt_q == '0);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    req_d     = req_q;
    timeout_d = timeout_q;
    rdata_d   = rdata_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          req_d.write = bus.req_write;
          req_d.addr  = bus.req_addr;
          req_d.wdata = bus.req_wdata;
          cnt_d       = '0;
          state_d     = ST_LOAD;
        end
      end

      ST_LOAD: begin
        cnt_d   = SETUP_LOAD;
        state_d = ST_SETUP;
      end

      ST_SETUP: begin
        if (cnt_zero) begin
          cnt_d   = STROBE_LOAD;
          state_d = ST_STROBE;
        end else begin
          cnt_d = cnt_q - cnt_t'(1);
        end
      end

      // The ready decision is made only in the last nominal strobe clock.
      ST_STROBE: begin
        if (!cnt_zero) begin
          cnt_d = cnt_q - cnt_t'(1);
        end else if (!rdy_sync) begin
          cnt_d   = TIMEOUT_LOAD;
          state_d = ST_WAIT_RDY;
        end else begin
          if (!req_q.write) rdata_d = bus.bus_rdata;
          cnt_d   = HOLD_LOAD;
          state_d = ST_HOLD;
        end
      end

      ST_WAIT_RDY: begin
        if (rdy_sync || cnt_zero) begin
          if (!req_q.write) rdata_d = bus.bus_rdata;
          timeout_d = !rdy_sync;
          cnt_d     = HOLD_LOAD;
          state_d   = ST_HOLD;
        end else begin
          cnt_d = cnt_q - cnt_t'(1);
        end
      end

      ST_HOLD: begin
        if (cnt_zero) begin
          cnt_d   = '0;
          state_d = ST_RESPOND;
        end else begin
          cnt_d = cnt_q - cnt_t'(1);
        end
      end

      ST_RESPOND: begin
        timeout_d = 1'b0;
        cnt_d     = '0;
        state_d   = ST_IDLE;
      end

      default: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  assign strobe_d = (state_d == ST_STROBE) || (state_d == ST_WAIT_RDY);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      req_q     <= '0;
      timeout_q <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      req_q     <= req_d;
      timeout_q <= timeout_d;
      rdata_q   <= rdata_d;
    end
  end

  // Outputs are decoded from the next state so each one lines up with its state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      req_ready_q    <= 1'b1;
      rsp_valid_q    <= 1'b0;
      rsp_timeout_q  <= 1'b0;
      address_load_q <= 1'b0;
      data_load_q    <= 1'b0;
      iow_q          <= 1'b1;
      ior_q          <= 1'b1;
    end else begin
      req_ready_q    <= (state_d == ST_IDLE);
      rsp_valid_q    <= (state_d == ST_RESPOND);
      rsp_timeout_q  <= (state_d == ST_RESPOND) && timeout_q;
      address_load_q <= (state_d == ST_LOAD);
      data_load_q    <= (state_d == ST_LOAD) && req_d.write;
      iow_q          <= !(strobe_d && req_d.write);
      ior_q          <= !(strobe_d && !req_d.write);
    end
  end

  assign bus.req_ready    = req_ready_q;
  assign bus.rsp_valid    = rsp_valid_q;
  assign bus.rsp_timeout  = rsp_timeout_q;
  assign bus.rsp_rdata    = rdata_q;
  assign bus.address_HPS  = req_q.addr;
  assign bus.data_HPS     = req_q.wdata;
  assign bus.address_load = address_load_q;
  assign bus.data_load    = data_load_q;
  assign bus.IOW          = iow_q;
  assign bus.IOR          = ior_q;

endmodule
